apb_uart_host: RTL and testbench

- APB initiator that drives the team's 16550-style APB UART slave from the other end of the bus.
- After reset it runs a fixed register-init sequence: divisor latch, line control, FIFO clear, interrupts off.
- It then polls LSR and moves bytes between two valid/ready byte streams and the UART's THR/RBR.
- It sits between a core-side byte-stream client and the UART's APB port, so software-free logic (boot loaders, debug bridges) can use the UART.

---
 rtl/apb_uart_host_if.sv | 23 ++
 rtl/apb_uart_host.sv | 216 +++++++++++++++++++++
 tb/tb_apb_uart_host.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_host_if.sv
// APB bus bundle between the UART host (master) and the UART slave.
interface apb_uart_host_if #(
    parameter int unsigned APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] PADDR;
    logic [31:0]               PWDATA;
    logic                      PWRITE;
    logic                      PSEL;
    logic                      PENABLE;
    logic [31:0]               PRDATA;
    logic                      PREADY;
    logic                      PSLVERR;

    modport master (
        output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_uart_host.sv
// APB initiator for the 16550-style UART: register init, then LSR-polled
// byte transfer between valid/ready streams and THR/RBR.
module apb_uart_host #(
    parameter int unsigned               APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
    parameter logic [15:0]               DIVISOR        = 16'd27,
    parameter logic [7:0]                LCR_CFG        = 8'h03,
    parameter int unsigned               POLL_GAP       = 2
) (
    input  logic                 CLK,
    input  logic                 RSTN,
    apb_uart_host_if.master      apb,
    input  logic [7:0]           tx_data_i,
    input  logic                 tx_valid_i,
    output logic                 tx_ready_o,
    output logic [7:0]           rx_data_o,
    output logic                 rx_err_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 init_done_o,
    output logic                 bus_err_o
);
    typedef enum logic [2:0] {
        S_INIT, S_GAP, S_POLL, S_DECIDE, S_RD_RBR, S_WR_THR
    } state_t;

    localparam logic [2:0] REG_DATA = 3'd0;
    localparam logic [2:0] REG_LSR  = 3'd5;
    localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

    state_t                    state_q, state_d;
    logic                      psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      pwrite_q, pwrite_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [7:0]                pwdata_q, pwdata_d;
    logic [2:0]                init_idx_q, init_idx_d;
    logic [7:0]                gap_cnt_q, gap_cnt_d;
    logic [2:0]                lsr_q, lsr_d;
    logic [7:0]                rx_data_q, rx_data_d;
    logic                      rx_err_q, rx_err_d;
    logic                      rx_valid_q, rx_valid_d;
    logic                      init_done_q, init_done_d;
    logic                      bus_err_q, bus_err_d;
    logic [2:0]                init_reg;
    logic [7:0]                init_dat;
    logic                      done;
    logic                      rx_go;
    logic                      tx_go;
    logic                      unused_prdata;

    function automatic logic [APB_ADDR_WIDTH-1:0] reg_addr(
        input logic [2:0] idx
    );
        return BASE_ADDR + APB_ADDR_WIDTH'(idx);
    endfunction

    assign done  = psel_q & penable_q & apb.PREADY;
    // lsr_q packs {THRE, PE, DR}
    assign rx_go = lsr_q[0] & ~rx_valid_q;
    assign tx_go = ~rx_go & lsr_q[2] & tx_valid_i;

    always_comb begin
        init_reg = 3'd3;
        init_dat = 8'h80;
        unique case (init_idx_q)
            3'd0: begin init_reg = 3'd3; init_dat = 8'h80;          end
            3'd1: begin init_reg = 3'd0; init_dat = DIVISOR[7:0];  end
            3'd2: begin init_reg = 3'd1; init_dat = DIVISOR[15:8]; end
            3'd3: begin init_reg = 3'd3; init_dat = LCR_CFG;       end
            3'd4: begin init_reg = 3'd2; init_dat = 8'h06;         end
            3'd5: begin init_reg = 3'd1; init_dat = 8'h00;         end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        init_idx_d  = init_idx_q;
        gap_cnt_d   = gap_cnt_q;
        lsr_d       = lsr_q;
        rx_data_d   = rx_data_q;
        rx_err_d    = rx_err_q;
        rx_valid_d  = rx_valid_q;
        init_done_d = init_done_q;
        bus_err_d   = bus_err_q;

        if (rx_valid_q && rx_ready_i) rx_valid_d = 1'b0;
        if (psel_q && !penable_q)     penable_d  = 1'b1;
        if (done) begin
            psel_d    = 1'b0;
            penable_d = 1'b0;
            if (apb.PSLVERR) bus_err_d = 1'b1;
        end

        // New transfers are launched from the cycle before SETUP
        unique case (state_q)
            S_INIT: begin
                if (done) begin
                    if (init_idx_q == 3'd5) begin
                        state_d     = S_GAP;
                        init_done_d = 1'b1;
                    end else begin
                        init_idx_d = init_idx_q + 3'd1;
                    end
                end else if (!psel_q) begin
                    psel_d   = 1'b1;
                    pwrite_d = 1'b1;
                    paddr_d  = reg_addr(init_reg);
                    pwdata_d = init_dat;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_POLL;
                    psel_d    = 1'b1;
                    pwrite_d  = 1'b0;
                    paddr_d   = reg_addr(REG_LSR);
                end else begin
                    gap_cnt_d = gap_cnt_q + 8'd1;
                end
            end
            S_POLL: begin
                if (done) begin
                    lsr_d   = {apb.PRDATA[5], apb.PRDATA[2], apb.PRDATA[0]};
                    state_d = S_DECIDE;
                end
            end
            S_DECIDE: begin
                unique case (1'b1)
                    rx_go: begin
                        state_d  = S_RD_RBR;
                        psel_d   = 1'b1;
                        pwrite_d = 1'b0;
                        paddr_d  = reg_addr(REG_DATA);
                    end
                    tx_go: begin
                        state_d  = S_WR_THR;
                        psel_d   = 1'b1;
                        pwrite_d = 1'b1;
                        paddr_d  = reg_addr(REG_DATA);
                        pwdata_d = tx_data_i;
                    end
                    default: state_d = S_GAP;
                endcase
            end
            S_RD_RBR: begin
                if (done) begin
                    rx_data_d  = apb.PRDATA[7:0];
                    rx_err_d   = lsr_q[1];
                    rx_valid_d = 1'b1;
                    state_d    = S_GAP;
                end
            end
            S_WR_THR: begin
                if (done) state_d = S_GAP;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= S_INIT;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            init_idx_q  <= '0;
            gap_cnt_q   <= '0;
            lsr_q       <= '0;
            rx_data_q   <= '0;
            rx_err_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            init_idx_q  <= init_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            lsr_q       <= lsr_d;
            rx_data_q   <= rx_data_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign apb.PSEL    = psel_q;
    assign apb.PENABLE = penable_q;
    assign apb.PWRITE  = pwrite_q;
    assign apb.PADDR   = paddr_q;
    assign apb.PWDATA  = {24'h0, pwdata_q};

    assign tx_ready_o  = (state_q == S_WR_THR) & done;
    assign rx_data_o   = rx_data_q;
    assign rx_err_o    = rx_err_q;
    assign rx_valid_o  = rx_valid_q;
    assign init_done_o = init_done_q;
    assign bus_err_o   = bus_err_q;

    assign unused_prdata = ^apb.PRDATA[31:8];
endmodule

// File: tb/tb_apb_uart_host.sv
// Directed bench for apb_uart_host: APB slave model, transfer monitor,
// hand-computed expectations.
module tb_apb_uart_host;
    localparam int POLL_GAP = 2;

    typedef struct {
        logic        wr;
        logic [11:0] addr;
        logic [31:0] data;
        int          en;
        bit          stable;
        int          idle;
        bit          txr;
    } rec_t;

    logic       CLK;
    logic       RSTN;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_err;
    logic       rx_valid;
    logic       rx_ready;
    logic       init_done;
    logic       bus_err;

    logic [7:0] lsr_val;
    logic [7:0] rbr_val;
    int         stall_req;
    int         acc_cnt;
    logic       slverr_cfg;

    int   n_chk;
    int   n_fail;
    int   cyc;
    int   last_done;
    int   txr_cnt;
    int   rp;
    bit   was_setup;
    rec_t cur;
    rec_t recs[$];

    apb_uart_host_if #(.APB_ADDR_WIDTH(12)) bus ();

    apb_uart_host #(
        .APB_ADDR_WIDTH(12),
        .BASE_ADDR     (12'h000),
        .DIVISOR       (16'd27),
        .LCR_CFG       (8'h03),
        .POLL_GAP      (POLL_GAP)
    ) dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .apb        (bus.master),
        .tx_data_i  (tx_data),
        .tx_valid_i (tx_valid),
        .tx_ready_o (tx_ready),
        .rx_data_o  (rx_data),
        .rx_err_o   (rx_err),
        .rx_valid_o (rx_valid),
        .rx_ready_i (rx_ready),
        .init_done_o(init_done),
        .bus_err_o  (bus_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // UART slave model: LSR at index 5, RBR at index 0; THR writes may stall
    logic stall_hit;
    assign stall_hit = bus.PSEL && bus.PENABLE && bus.PWRITE &&
                       (bus.PADDR[2:0] == 3'd0);
    assign bus.PREADY  = !(stall_hit && (acc_cnt < stall_req));
    assign bus.PSLVERR = slverr_cfg && bus.PWRITE && (bus.PADDR[2:0] == 3'd0);
    assign bus.PRDATA  = (bus.PADDR[2:0] == 3'd5) ? {24'h0, lsr_val} :
                         (bus.PADDR[2:0] == 3'd0) ? {24'h0, rbr_val} : 32'h0;

    initial begin
        acc_cnt = 0;
        forever begin
            @(posedge CLK);
            if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
            else if (!bus.PENABLE) acc_cnt <= 0;
        end
    end

    initial begin
        cyc = 0; last_done = 0; txr_cnt = 0; was_setup = 0;
        forever begin
            @(negedge CLK);
            cyc++;
            if (tx_ready) txr_cnt++;
            if (!RSTN) begin
                last_done = cyc;
                was_setup = 0;
            end else if (bus.PSEL && !bus.PENABLE) begin
                if (was_setup) begin
                    cur.stable = 0;
                end else begin
                    cur.wr     = bus.PWRITE;
                    cur.addr   = bus.PADDR;
                    cur.data   = bus.PWDATA;
                    cur.en     = 0;
                    cur.stable = 1;
                    cur.idle   = cyc - last_done - 1;
                    cur.txr    = 0;
                end
                was_setup = 1;
            end else begin
                was_setup = 0;
                if (bus.PSEL && bus.PENABLE) begin
                    cur.en++;
                    if (bus.PADDR != cur.addr || bus.PWRITE != cur.wr ||
                        (cur.wr && bus.PWDATA != cur.data))
                        cur.stable = 0;
                    if (bus.PREADY) begin
                        if (!cur.wr) cur.data = bus.PRDATA;
                        cur.txr = tx_ready;
                        recs.push_back(cur);
                        last_done = cyc;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic next_rec(output rec_t r);
        int k;
        k = 0;
        while (recs.size() <= rp && k < 300) begin
            tick();
            k++;
        end
        if (recs.size() > rp) begin
            r = recs[rp];
            rp++;
        end else begin
            r = '{default: 0};
            chk("rec_timeout", 64'(recs.size()), 64'(rp + 1));
        end
    endtask

    task automatic next_op(output rec_t r);
        for (int i = 0; i < 8; i++) begin
            next_rec(r);
            if (r.wr || r.addr[2:0] != 3'd5) return;
        end
        chk("op_seen", 64'(r.addr[2:0]), 64'd0);
    endtask

    task automatic check_init();
        logic [11:0] ia [6];
        logic [7:0]  id [6];
        rec_t        r;
        ia = '{12'd3, 12'd0, 12'd1, 12'd3, 12'd2, 12'd1};
        id = '{8'h80, 8'h1B, 8'h00, 8'h03, 8'h06, 8'h00};
        for (int i = 0; i < 6; i++) begin
            next_rec(r);
            chk($sformatf("init_wr%0d", i), {r.wr, r.addr, r.data},
                {1'b1, ia[i], 24'h0, id[i]});
            chk("init_en", 64'(r.en), 64'd1);
            chk("init_stable", 64'(r.stable), 64'd1);
            if (i > 0) chk("init_gap", 64'(r.idle), 64'd1);
            if (i == 4) chk("init_done_early", 64'(init_done), 64'd0);
        end
        chk("init_done", 64'(init_done), 64'd1);
    endtask

    initial begin
        rec_t r;
        bit   found;
        n_chk = 0; n_fail = 0; rp = 0;
        RSTN = 0; tx_valid = 0; tx_data = 0; rx_ready = 0;
        lsr_val = 0; rbr_val = 0; stall_req = 0; slverr_cfg = 0;
        repeat (3) @(negedge CLK);
        chk("rst_bus", {bus.PSEL, bus.PENABLE, bus.PWRITE, bus.PADDR,
                        bus.PWDATA}, 64'd0);
        chk("rst_out", {tx_ready, rx_valid, rx_data, rx_err, init_done,
                        bus_err}, 64'd0);

        tx_valid = 1; tx_data = 8'h55;
        @(negedge CLK);
        RSTN = 1;
        check_init();

        next_rec(r);
        chk("poll1", {r.wr, r.addr}, {1'b0, 12'h005});
        chk("poll1_gap", 64'(r.idle), 64'(POLL_GAP));
        next_rec(r);
        chk("poll2", {r.wr, r.addr}, {1'b0, 12'h005});
        chk("poll2_gap", 64'(r.idle), 64'(POLL_GAP + 1));
        chk("no_txr", 64'(txr_cnt), 64'd0);

        lsr_val = 8'h60;
        next_rec(r);
        chk("poll3", {r.wr, r.addr, r.data}, {1'b0, 12'h005, 32'h60});
        next_rec(r);
        chk("thr_wr", {r.wr, r.addr, r.data}, {1'b1, 12'h000, 32'h55});
        chk("thr_txr", 64'(r.txr), 64'd1);
        chk("thr_gap", 64'(r.idle), 64'd1);
        tx_valid = 0;
        tick(); tick();
        chk("txr_pulse", 64'(txr_cnt), 64'd1);

        lsr_val = 8'h61; rbr_val = 8'hA5;
        rp = recs.size();
        next_op(r);
        chk("rbr_rd", {r.wr, r.addr, r.data}, {1'b0, 12'h000, 32'hA5});
        chk("rx_out", {rx_valid, rx_data, rx_err}, {1'b1, 8'hA5, 1'b0});
        next_rec(r);
        chk("hold_poll_a", {r.wr, r.addr}, {1'b0, 12'h005});
        next_rec(r);
        chk("hold_poll_b", {r.wr, r.addr}, {1'b0, 12'h005});
        chk("rx_held", {rx_valid, rx_data}, {1'b1, 8'hA5});
        tick();
        rx_ready = 1;
        tick();
        chk("rx_clr", 64'(rx_valid), 64'd0);
        rx_ready = 0;
        next_op(r);
        chk("rbr_again", {r.wr, r.addr, r.data}, {1'b0, 12'h000, 32'hA5});
        chk("rx_again", {rx_valid, rx_data}, {1'b1, 8'hA5});

        next_rec(r);
        tick();
        lsr_val = 8'h65; rbr_val = 8'h3C;
        tx_valid = 1; tx_data = 8'h9A; rx_ready = 1;
        tick();
        rx_ready = 0;
        next_op(r);
        chk("prio_rbr", {r.wr, r.addr, r.data}, {1'b0, 12'h000, 32'h3C});
        chk("prio_rx", {rx_valid, rx_data, rx_err}, {1'b1, 8'h3C, 1'b1});
        next_op(r);
        chk("prio_thr", {r.wr, r.addr, r.data}, {1'b1, 12'h000, 32'h9A});
        chk("bus_err0", 64'(bus_err), 64'd0);

        lsr_val = 8'h60; tx_data = 8'hC3;
        stall_req = 5; slverr_cfg = 1;
        next_op(r);
        chk("stall_thr", {r.wr, r.addr, r.data}, {1'b1, 12'h000, 32'hC3});
        chk("stall_en", 64'(r.en), 64'd6);
        chk("stall_stable", 64'(r.stable), 64'd1);
        chk("stall_txr", 64'(r.txr), 64'd1);
        chk("bus_err1", 64'(bus_err), 64'd1);
        tx_valid = 0; stall_req = 0; slverr_cfg = 0; lsr_val = 8'h00;
        next_rec(r);
        next_rec(r);
        chk("bus_err_sticky", 64'(bus_err), 64'd1);
        chk("txr_total", 64'(txr_cnt), 64'd3);

        lsr_val = 8'h61; rbr_val = 8'h77; rx_ready = 1;
        tick();
        rx_ready = 0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (bus.PSEL && bus.PENABLE && !bus.PWRITE &&
                bus.PADDR[2:0] == 3'd0)
                found = 1;
        end
        chk("rbr_access_seen", 64'(found), 64'd1);
        RSTN = 0;
        #1;
        chk("mid_rst_bus", {bus.PSEL, bus.PENABLE}, 64'd0);
        chk("mid_rst_out", {rx_valid, init_done, bus_err}, 64'd0);
        lsr_val = 8'h00;
        tick(); tick();
        @(negedge CLK);
        RSTN = 1;
        rp = recs.size();
        check_init();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
